// File: rtl/hash_out_mem_writer_pkg.sv
// Shared types and defaults for the hash output RAM writer.
// FSM encoding and width defaults; HASH_OUT_TAIL_MASK_EN selects tail masking in the writer.
package hash_out_mem_writer_pkg;

  localparam int unsigned IO_WIDTH_DEF      = 32;
  localparam int unsigned MAX_RAM_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FORCE   = 2'd2,
    S_DONE    = 2'd3
  } hash_out_state_e;

  // Address width for a RAM of the given depth; a 1-word RAM still needs one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hash_out_tail_mask.sv
// Clears the bits of the final digest word that lie past the requested length.
// Compiled only when HASH_OUT_TAIL_MASK_EN is defined.
`ifdef HASH_OUT_TAIL_MASK_EN
module hash_out_tail_mask
  import hash_out_mem_writer_pkg::*;
#(
  parameter  int unsigned IO_WIDTH = IO_WIDTH_DEF,
  localparam int unsigned TW       = $clog2(IO_WIDTH) + 1
) (
  input  logic [IO_WIDTH-1:0] i_data,
  input  logic [TW-1:0]       i_tail_bits,
  input  logic                i_last,
  output logic [IO_WIDTH-1:0] o_data_c
);

  logic [IO_WIDTH-1:0] keep_c;

  // Keep the top i_tail_bits bits; digest is presented MSB-first.
  always_comb begin
    keep_c   = ~({IO_WIDTH{1'b1}} >> i_tail_bits);
    o_data_c = i_data;
    if (i_last && (i_tail_bits != '0)) begin
      o_data_c = i_data & keep_c;
    end
  end

endmodule
`endif

// File: rtl/hash_out_mem_writer.sv
// Collects digest words from the hash interface and writes them to an output RAM,
// then asks the hash core to stop squeezing. Tail masking under HASH_OUT_TAIL_MASK_EN.
module hash_out_mem_writer
  import hash_out_mem_writer_pkg::*;
#(
  parameter  int unsigned IO_WIDTH      = IO_WIDTH_DEF,
  parameter  int unsigned MAX_RAM_DEPTH = MAX_RAM_DEPTH_DEF,
  localparam int unsigned AW            = addr_width(MAX_RAM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [IO_WIDTH-1:0] i_output_length,
  input  logic [AW-1:0]       i_base_addr,
  input  logic [IO_WIDTH-1:0] i_data_in,
  input  logic                i_data_in_valid,
  output logic                o_data_in_ready,
  output logic [AW-1:0]       o_addr,
  output logic                o_wr_en,
  output logic [IO_WIDTH-1:0] o_data_out,
  output logic                o_force_done,
  input  logic                i_force_done_ack,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [IO_WIDTH-1:0] W_VEC     = IO_WIDTH'(IO_WIDTH);
  localparam logic [AW-1:0]       LAST_ADDR = AW'(MAX_RAM_DEPTH - 1);

  hash_out_state_e     state_q, state_d;
  logic [IO_WIDTH-1:0] cnt_q, cnt_d;
  logic [IO_WIDTH-1:0] n_q, n_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [IO_WIDTH-1:0] data_q, data_d;
  logic                wr_en_q, wr_en_d;
  logic                force_done_q, force_done_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IO_WIDTH-1:0] n_start_c;
  logic                last_c;
  logic [IO_WIDTH-1:0] word_c;

  assign n_start_c = (i_output_length / W_VEC) + IO_WIDTH'((i_output_length % W_VEC) != '0);
  assign last_c    = ((cnt_q + IO_WIDTH'(1)) == n_q);

`ifdef HASH_OUT_TAIL_MASK_EN
  localparam int unsigned TW = $clog2(IO_WIDTH) + 1;
  logic [TW-1:0] tail_q, tail_d;

  hash_out_tail_mask #(
    .IO_WIDTH (IO_WIDTH)
  ) u_tail_mask (
    .i_data      (i_data_in),
    .i_tail_bits (tail_q),
    .i_last      (last_c),
    .o_data_c    (word_c)
  );
`else
  assign word_c = i_data_in;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
`ifdef HASH_OUT_TAIL_MASK_EN
    tail_d  = tail_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d     = n_start_c;
          cnt_d   = '0;
          ptr_d   = i_base_addr;
`ifdef HASH_OUT_TAIL_MASK_EN
          tail_d  = TW'(i_output_length % W_VEC);
`endif
          state_d = (n_start_c == '0) ? S_FORCE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_data_in_valid) begin
          wr_en_d = 1'b1;
          addr_d  = ptr_q;
          data_d  = word_c;
          ptr_d   = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AW'(1);
          cnt_d   = cnt_q + IO_WIDTH'(1);
          if (last_c) begin
            state_d = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        if (i_force_done_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    force_done_d = (state_d == S_FORCE);
    busy_d       = (state_d == S_COLLECT) || (state_d == S_FORCE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      force_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef HASH_OUT_TAIL_MASK_EN
      tail_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      force_done_q <= force_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef HASH_OUT_TAIL_MASK_EN
      tail_q       <= tail_d;
`endif
    end
  end

  assign o_data_in_ready = (state_q == S_COLLECT);
  assign o_addr          = addr_q;
  assign o_wr_en         = wr_en_q;
  assign o_data_out      = data_q;
  assign o_force_done    = force_done_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

// File: doc/hash_out_mem_writer.md
HASH_OUT_MEM_WRITER -- requirements
Module: hash_out_mem_writer

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 32, meaning stream/RAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter MAX_RAM_DEPTH, default 16, meaning output RAM depth in words; address width CLOG2(MAX_RAM_DEPTH).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start pulse.
- i_output_length  in  IO_WIDTH  requested digest length in bits.
- i_base_addr  in  CLOG2(MAX_RAM_DEPTH)  first RAM write address.
- i_data_in  in  IO_WIDTH  hash output word from the hash memory interface.
- i_data_in_valid  in  1  word valid.
- o_data_in_ready  out  1  word accepted when valid&ready.
- o_addr  out  CLOG2(MAX_RAM_DEPTH)  RAM write address.
- o_wr_en  out  1  RAM write strobe.
- o_data_out  out  IO_WIDTH  RAM write data.
- o_force_done  out  1  request to the hash core to abort squeezing.
- i_force_done_ack  in  1  hash core acknowledge.
- o_busy  out  1  high from accepted start until done.
- o_done  out  1  one-cycle completion pulse.

Function
REQ-004 SHALL implement FSM states S_IDLE, S_COLLECT, S_FORCE, S_DONE.
REQ-005 S_IDLE: on i_start, latch length and base address, compute N = ceil(i_output_length/IO_WIDTH), go to S_COLLECT (S_FORCE if N = 0).
REQ-006 o_data_in_ready SHALL be 1 only in S_COLLECT; it is combinational on state.
REQ-007 On each handshake in S_COLLECT, the word SHALL be registered and written next cycle: o_wr_en=1, o_data_out=word, o_addr=base+k (k = word index); one-cycle write latency.
REQ-008 Address SHALL wrap modulo MAX_RAM_DEPTH; no error is flagged on wrap.
REQ-009 When the N-th word is accepted, the FSM SHALL go to S_FORCE in the next cycle; no further words are accepted.
REQ-010 S_FORCE: o_force_done=1 held until i_force_done_ack=1, then go to S_DONE; an ack arriving in the first S_FORCE cycle SHALL be honoured.
REQ-011 S_DONE: o_done=1 for exactly one cycle, then S_IDLE; o_busy=1 in S_COLLECT and S_FORCE.
REQ-012 i_start while not in S_IDLE SHALL be ignored.
REQ-013 i_data_in_valid outside S_COLLECT SHALL be ignored (no write, no counter change).
REQ-014 Word counter SHALL be IO_WIDTH bits wide; i_output_length up to 2^IO_WIDTH-1 is legal.

Reset
REQ-015 rst SHALL force S_IDLE and clear o_wr_en, o_force_done, o_done, o_busy, o_data_in_ready, o_addr, o_data_out and counters in the next clock edge, including mid-operation.
REQ-016 After rst release, the block SHALL accept i_start on the first cycle.

Configuration
REQ-017 Macro HASH_OUT_TAIL_MASK_EN: when defined, the last word SHALL have bits beyond (i_output_length mod IO_WIDTH) forced to 0, counting from the MSB byte (big-endian as presented by the hash interface); when undefined, the last word is written unmodified.
REQ-018 Mask SHALL not apply when i_output_length is a multiple of IO_WIDTH.

Structure
REQ-019 FSM state encodings and IO_WIDTH default SHALL live in the shared hash include header alongside clog2.v.
REQ-020 Tail masking SHALL be a sub-module hash_out_tail_mask (combinational), instantiated only under HASH_OUT_TAIL_MASK_EN.

Verification
REQ-021 Length 256, base 0, continuous valid -> 8 writes addr 0..7, force_done, ack, o_done pulse.
REQ-022 Length 40, mask enabled, words 0xAABBCCDD,0x11223344 -> RAM[1]=0x11000000; mask disabled -> 0x11223344.
REQ-023 Length 0 -> no writes, o_force_done immediately, done after ack.
REQ-024 Length 128, base 14, depth 16 -> writes at 14,15,0,1.
REQ-025 Valid toggling every other cycle with ack delayed 5 cycles -> exactly N writes, force_done held 5+ cycles.
REQ-026 rst asserted after 3 of 8 words -> all outputs 0 next cycle; new start proceeds from base.
